nebula_local_injector: RTL and testbench

//  Local-port packet transmitter for one mesh node. Turns a packet request plus buffered payload

---
 rtl/nebula_local_injector.sv | 194 +++++++++++++++++++
 tb/tb_nebula_local_injector.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nebula_local_injector.sv
// Local-port packet injector: turns a packet request plus buffered payload words into a
// HEAD/BODY/TAIL (or SINGLE) flit stream on a router local input port.
module nebula_local_injector #(
    parameter int NODE_X        = 0,
    parameter int NODE_Y        = 0,
    parameter int DATA_W        = 64,
    parameter int PAYLOAD_DEPTH = 8,
    parameter int MAX_LEN       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_dest_x,
    input  logic [7:0]        req_dest_y,
    input  logic [7:0]        req_len,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              flit_out_valid,
    input  logic              flit_out_ready,
    output logic [DATA_W+1:0] flit_out,
    output logic              busy,
    output logic [31:0]       packets_sent,
    output logic              err_len
);

    // state | meaning
    // IDLE  | accepting requests; oversize requests are dropped and flagged
    // HEAD  | presenting the HEAD (or SINGLE) flit until the router takes it
    // BODY  | streaming payload words from the FIFO; last one is typed TAIL
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam int AW = (PAYLOAD_DEPTH > 1) ? $clog2(PAYLOAD_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(PAYLOAD_DEPTH);
    localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [7:0]  NODE_X8  = 8'(NODE_X);
    localparam logic [7:0]  NODE_Y8  = 8'(NODE_Y);

    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    state_t state;

    logic [DATA_W-1:0] mem [PAYLOAD_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [7:0] pkt_id;
    logic [7:0] cur_id;
    logic [7:0] cur_dest_x;
    logic [7:0] cur_dest_y;
    logic [7:0] cur_len;
    logic [7:0] remaining;

    logic [1:0]        flit_type;
    logic [DATA_W-1:0] flit_data;
    logic [DATA_W-1:0] head_data;

    assign fifo_full     = (count == DEPTH_C);
    assign fifo_empty    = (count == '0);
    assign data_in_ready = !fifo_full;
    // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
    assign push          = data_in_valid && !fifo_full;
    assign pop           = (state == S_BODY) && !fifo_empty && flit_out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req_ready    <= 1'b0;
            pkt_id       <= '0;
            cur_id       <= '0;
            cur_dest_x   <= '0;
            cur_dest_y   <= '0;
            cur_len      <= '0;
            remaining    <= '0;
            packets_sent <= '0;
            err_len      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if (req_len > MAX_LEN8) begin
                            err_len <= 1'b1;
                        end else begin
                            cur_dest_x <= req_dest_x;
                            cur_dest_y <= req_dest_y;
                            cur_len    <= req_len;
                            cur_id     <= pkt_id;
                            pkt_id     <= pkt_id + 8'd1;
                            req_ready  <= 1'b0;
                            state      <= S_HEAD;
                        end
                    end
                end
                S_HEAD: begin
                    if (flit_out_ready) begin
                        if (cur_len == 8'd0) begin
                            packets_sent <= packets_sent + 32'd1;
                            req_ready    <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            remaining <= cur_len;
                            state     <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (pop) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            packets_sent <= packets_sent + 32'd1;
                            req_ready    <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        head_data        = '0;
        head_data[47:0]  = {cur_id, cur_len, NODE_Y8, NODE_X8, cur_dest_y, cur_dest_x};
    end

    // Outputs decode only registered state, so valid/data cannot glitch with ready.
    always_comb begin
        flit_out_valid = 1'b0;
        flit_type      = T_HEAD;
        flit_data      = '0;
        case (state)
            S_HEAD: begin
                flit_out_valid = 1'b1;
                flit_type      = (cur_len == 8'd0) ? T_SINGLE : T_HEAD;
                flit_data      = head_data;
            end
            S_BODY: begin
                flit_out_valid = !fifo_empty;
                flit_type      = (remaining == 8'd1) ? T_TAIL : T_BODY;
                flit_data      = fifo_empty ? '0 : mem[rd_ptr];
            end
            default: begin
                flit_out_valid = 1'b0;
            end
        endcase
    end

    assign flit_out = {flit_type, flit_data};
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_nebula_local_injector.sv
// Directed plus randomized bench for nebula_local_injector; expected flits come from a
// packet-level model (payload queue, packet counter, pkt_id counter).
module tb_nebula_local_injector;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int MAXL  = 16;
    localparam int NX    = 1;
    localparam int NY    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_dest_x;
    logic [7:0]    req_dest_y;
    logic [7:0]    req_len;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_in;
    logic          flit_out_valid;
    logic          flit_out_ready;
    logic [DW+1:0] flit_out;
    logic          busy;
    logic [31:0]   packets_sent;
    logic          err_len;

    nebula_local_injector #(
        .NODE_X(NX), .NODE_Y(NY), .DATA_W(DW), .PAYLOAD_DEPTH(DEPTH), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
        .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready), .flit_out(flit_out),
        .busy(busy), .packets_sent(packets_sent), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] fifo_q[$];
    int            cur_len, cur_idx, cur_dx, cur_dy, cur_id;
    int            pkt_id_m, pkts_m;
    logic          err_m;
    int            max_wait;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] exp_flit();
        if (cur_idx == 0)
            return {(cur_len == 0) ? 2'b11 : 2'b00, 16'h0, 8'(cur_id), 8'(cur_len),
                    8'(NY), 8'(NX), 8'(cur_dy), 8'(cur_dx)};
        if (fifo_q.size() == 0)
            return '1;
        return {(cur_idx == cur_len) ? 2'b10 : 2'b01, fifo_q[0]};
    endfunction

    task automatic model_handshake();
        if (cur_idx > 0) void'(fifo_q.pop_front());
        cur_idx++;
        if (cur_idx == cur_len + 1) pkts_m++;
    endtask

    task automatic model_reset();
        fifo_q.delete();
        pkts_m   = 0;
        pkt_id_m = 0;
        err_m    = 1'b0;
        cur_idx  = 0;
        cur_len  = 0;
    endtask

    task automatic push_one();
        logic [DW-1:0] w;
        w = {$urandom, $urandom};
        chk("din_ready", 66'(data_in_ready), 66'(fifo_q.size() < DEPTH));
        data_in_valid = 1'b1;
        data_in       = w;
        step();
        data_in_valid = 1'b0;
        if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
    endtask

    task automatic send_req(input int dx, input int dy, input int len);
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk("req_ready_wait", 66'(req_ready), 66'(1));
        req_valid  = 1'b1;
        req_dest_x = 8'(dx);
        req_dest_y = 8'(dy);
        req_len    = 8'(len);
        step();
        req_valid = 1'b0;
        if (len > MAXL) begin
            err_m = 1'b1;
            chk("err_len_set", 66'(err_len), 66'(1));
            chk("drop_no_flit", 66'(flit_out_valid), 66'(0));
            chk("drop_not_busy", 66'(busy), 66'(0));
        end else begin
            cur_len  = len;
            cur_dx   = dx;
            cur_dy   = dy;
            cur_id   = pkt_id_m;
            pkt_id_m = (pkt_id_m + 1) % 256;
            cur_idx  = 0;
            chk("head_latency", 66'(flit_out_valid), 66'(1));
            chk("busy_on", 66'(busy), 66'(1));
            chk("req_ready_low", 66'(req_ready), 66'(0));
        end
    endtask

    // feed bit0: supply a word when the packet starves; bit1: random push alongside handshakes
    task automatic recv_flits(input int n, input int max_stall, input int stall_idx,
                              input int stall_n, input int feed);
        logic [65:0]   e;
        logic [DW-1:0] w;
        int            waited, stall;
        bit            acc;
        max_wait = 0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (flit_out_valid !== 1'b1) begin
                if (waited >= 100) begin
                    chk("flit_timeout", 66'(flit_out_valid), 66'(1));
                    return;
                end
                if ((feed & 1) != 0 && cur_idx > 0 && fifo_q.size() == 0) push_one();
                else step();
                waited++;
            end
            if (i > 0 && waited > max_wait) max_wait = waited;
            e     = exp_flit();
            stall = (i == stall_idx) ? stall_n : int'($urandom_range(0, max_stall));
            for (int s = 0; s < stall; s++) begin
                chk("stall_valid", 66'(flit_out_valid), 66'(1));
                chk("stall_flit", flit_out, e);
                step();
            end
            chk("flit_valid", 66'(flit_out_valid), 66'(1));
            chk("flit", flit_out, e);
            acc = 1'b0;
            if ((feed & 2) != 0 && $urandom_range(0, 1) == 1) begin
                w   = {$urandom, $urandom};
                acc = (fifo_q.size() < DEPTH);
                chk("din_ready_cc", 66'(data_in_ready), 66'(acc));
                data_in_valid = 1'b1;
                data_in       = w;
            end
            flit_out_ready = 1'b1;
            step();
            flit_out_ready = 1'b0;
            data_in_valid  = 1'b0;
            model_handshake();
            if (acc) fifo_q.push_back(w);
        end
    endtask

    task automatic check_idle();
        chk("idle_busy", 66'(busy), 66'(0));
        chk("idle_valid", 66'(flit_out_valid), 66'(0));
        chk("idle_req_ready", 66'(req_ready), 66'(1));
        chk("packets_sent", 66'(packets_sent), 66'(pkts_m));
        chk("err_len", 66'(err_len), 66'(err_m));
    endtask

    initial begin
        logic [65:0] e;
        int          len, pre;
        rst = 1'b1; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0; req_len = '0;
        data_in_valid = 1'b0; data_in = '0; flit_out_ready = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_req_ready", 66'(req_ready), 66'(0));
        chk("rst_valid", 66'(flit_out_valid), 66'(0));
        chk("rst_flit", flit_out, 66'(0));
        chk("rst_busy", 66'(busy), 66'(0));
        chk("rst_pkts", 66'(packets_sent), 66'(0));
        chk("rst_err", 66'(err_len), 66'(0));
        chk("rst_din_ready", 66'(data_in_ready), 66'(1));
        rst = 1'b0;
        step();

        // SINGLE flit for a zero-length packet
        send_req(3, 2, 0);
        chk("single_const", flit_out, {2'b11, 16'h0, 48'h00_00_01_01_02_03});
        recv_flits(1, 0, -1, 0, 0);
        check_idle();

        // preloaded three-word packet, back to back flits
        for (int i = 0; i < 3; i++) push_one();
        send_req(5, 6, 3);
        recv_flits(4, 0, -1, 0, 0);
        chk("consecutive", 66'(max_wait), 66'(0));
        check_idle();

        // five-cycle stall on the second payload flit
        for (int i = 0; i < 3; i++) push_one();
        send_req(7, 1, 3);
        recv_flits(4, 0, 2, 5, 0);
        check_idle();

        // payload starves mid-packet, then resumes
        for (int i = 0; i < 2; i++) push_one();
        send_req(2, 9, 4);
        recv_flits(3, 0, -1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("starve_valid", 66'(flit_out_valid), 66'(0));
            chk("starve_busy", 66'(busy), 66'(1));
            step();
        end
        push_one();
        push_one();
        recv_flits(2, 1, -1, 0, 0);
        check_idle();

        // full FIFO refuses a push that coincides with a pop
        for (int i = 0; i < DEPTH; i++) push_one();
        chk("full_din_ready", 66'(data_in_ready), 66'(0));
        send_req(4, 4, 9);
        recv_flits(1, 0, -1, 0, 0);
        e = exp_flit();
        chk("full_pop_flit", flit_out, e);
        data_in_valid  = 1'b1;
        data_in        = 64'hDEAD_BEEF_0BAD_F00D;
        flit_out_ready = 1'b1;
        step();
        data_in_valid  = 1'b0;
        flit_out_ready = 1'b0;
        model_handshake();
        chk("after_pop_din_ready", 66'(data_in_ready), 66'(1));
        recv_flits(8, 1, -1, 0, 1);
        check_idle();

        // oversize request dropped; pkt_id not consumed
        send_req(1, 1, 17);
        for (int i = 0; i < 3; i++) begin
            chk("drop_quiet", 66'(flit_out_valid), 66'(0));
            step();
        end
        check_idle();
        send_req(8, 8, 0);
        recv_flits(1, 0, -1, 0, 0);
        check_idle();

        // reset in BODY with three words still buffered
        for (int i = 0; i < 5; i++) push_one();
        send_req(6, 3, 5);
        recv_flits(3, 0, -1, 0, 0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 66'(flit_out_valid), 66'(0));
        chk("mid_rst_din_ready", 66'(data_in_ready), 66'(1));
        chk("mid_rst_busy", 66'(busy), 66'(0));
        chk("mid_rst_pkts", 66'(packets_sent), 66'(0));
        chk("mid_rst_err", 66'(err_len), 66'(0));
        rst = 1'b0;
        model_reset();
        step();
        send_req(9, 2, 1);
        recv_flits(1, 0, -1, 0, 0);
        chk("flushed_fifo", 66'(flit_out_valid), 66'(0));
        push_one();
        recv_flits(1, 0, -1, 0, 0);
        check_idle();

        // randomized packets with random stalls and concurrent pushes
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(0, 18));
            pre = int'($urandom_range(0, DEPTH - fifo_q.size()));
            for (int i = 0; i < pre; i++) push_one();
            send_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), len);
            if (len <= MAXL) recv_flits(len + 1, 2, -1, 0, 3);
            check_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
